// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : div_unit_pkg
// Brief  : Shared bus widths, control constants and FSM encoding for div_unit.
// Rev    : 1.0
// ============================================================================
package div_unit_pkg;

    localparam int c_reg_width        = 32;
    localparam int c_double_reg_width = 64;

    localparam logic [c_reg_width-1:0] c_zero_word = '0;

    localparam logic c_rst_enable           = 1'b1;
    localparam logic c_div_result_ready     = 1'b1;
    localparam logic c_div_result_not_ready = 1'b0;
    localparam logic c_div_start            = 1'b1;
    localparam logic c_div_stop             = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
// Module : div_unit_if
// Brief  : EX-stage <-> divider request/result bundle.
//          DIV_BYZERO_FLAG_EN adds the div_by_zero status bit.
// Rev    : 1.0
// ============================================================================
interface div_unit_if
    import div_unit_pkg::*;
#(
    parameter int WIDTH = c_reg_width
) ();

    logic               signed_div;
    logic [WIDTH-1:0]   opdata1;
    logic [WIDTH-1:0]   opdata2;
    logic               start;
    logic               annul;
    logic [2*WIDTH-1:0] result;
    logic               ready;
`ifdef DIV_BYZERO_FLAG_EN
    logic               div_by_zero;

    modport master (
        output signed_div, opdata1, opdata2, start, annul,
        input  result, ready, div_by_zero
    );

    modport slave (
        input  signed_div, opdata1, opdata2, start, annul,
        output result, ready, div_by_zero
    );
`else
    modport master (
        output signed_div, opdata1, opdata2, start, annul,
        input  result, ready
    );

    modport slave (
        input  signed_div, opdata1, opdata2, start, annul,
        output result, ready
    );
`endif

endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module : div_unit
// Brief  : Iterative radix-2 restoring divider for DIV/DIVU, one bit per cycle.
//          Optional macro DIV_BYZERO_FLAG_EN drives dif.div_by_zero.
// Rev    : 1.0
// ============================================================================
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = c_reg_width
) (
    input  wire logic   clk,
    input  wire logic   rst,
    div_unit_if.slave   dif
);

    localparam int                 CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_t         r_state,   w_state_next;
    logic [CNT_W-1:0]   r_counter, w_counter_next;
    logic [WIDTH-1:0]   r_rem,     w_rem_next;
    logic [WIDTH-1:0]   r_quot,    w_quot_next;
    logic [WIDTH-1:0]   r_divisor, w_divisor_next;
    logic               r_dvd_neg, w_dvd_neg_next;
    logic               r_dvs_neg, w_dvs_neg_next;
    logic [2*WIDTH-1:0] r_result,  w_result_next;
    logic               r_ready,   w_ready_next;

    // The shifted value is the 33-bit partial remainder; the quotient register
    // starts out holding the dividend and feeds its MSB in each step.
    logic [WIDTH:0]     w_shifted;
    logic               w_sub_ok;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_rem_step;
    logic [WIDTH-1:0]   w_quot_step;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_shifted   = {r_rem, r_quot[WIDTH-1]};
    assign w_sub_ok    = (w_shifted >= {1'b0, r_divisor});
    assign w_diff      = w_shifted[WIDTH-1:0] - r_divisor;
    assign w_rem_step  = w_sub_ok ? w_diff : w_shifted[WIDTH-1:0];
    assign w_quot_step = {r_quot[WIDTH-2:0], w_sub_ok};
    assign w_quot_fix  = (r_dvd_neg ^ r_dvs_neg) ? -w_quot_step : w_quot_step;
    assign w_rem_fix   = r_dvd_neg ? -w_rem_step : w_rem_step;

    always_comb begin
        w_state_next   = r_state;
        w_counter_next = r_counter;
        w_rem_next     = r_rem;
        w_quot_next    = r_quot;
        w_divisor_next = r_divisor;
        w_dvd_neg_next = r_dvd_neg;
        w_dvs_neg_next = r_dvs_neg;
        w_result_next  = r_result;
        w_ready_next   = c_div_result_not_ready;

        case (r_state)
            DivFree: begin
                if (dif.start == c_div_start && !dif.annul) begin
                    w_dvd_neg_next = dif.signed_div & dif.opdata1[WIDTH-1];
                    w_dvs_neg_next = dif.signed_div & dif.opdata2[WIDTH-1];
                    w_quot_next    = w_dvd_neg_next ? -dif.opdata1 : dif.opdata1;
                    w_divisor_next = w_dvs_neg_next ? -dif.opdata2 : dif.opdata2;
                    w_counter_next = '0;
                    w_rem_next     = '0;
                    w_state_next   = (dif.opdata2 == '0) ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                if (dif.annul) begin
                    w_state_next = DivFree;
                end else begin
                    w_result_next = '0;
                    w_state_next  = DivEnd;
                end
            end
            DivOn: begin
                if (dif.annul) begin
                    w_state_next = DivFree;
                end else begin
                    w_rem_next     = w_rem_step;
                    w_quot_next    = w_quot_step;
                    w_counter_next = r_counter + CNT_W'(1);
                    if (r_counter == LAST_ITER) begin
                        w_result_next = {w_rem_fix, w_quot_fix};
                        w_state_next  = DivEnd;
                    end
                end
            end
            DivEnd: begin
                if (dif.annul || dif.start == c_div_stop) begin
                    w_state_next = DivFree;
                end else begin
                    w_ready_next = c_div_result_ready;
                end
            end
            default: w_state_next = DivFree;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == c_rst_enable) begin
            r_state   <= DivFree;
            r_counter <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_dvd_neg <= 1'b0;
            r_dvs_neg <= 1'b0;
            r_result  <= '0;
            r_ready   <= c_div_result_not_ready;
        end else begin
            r_state   <= w_state_next;
            r_counter <= w_counter_next;
            r_rem     <= w_rem_next;
            r_quot    <= w_quot_next;
            r_divisor <= w_divisor_next;
            r_dvd_neg <= w_dvd_neg_next;
            r_dvs_neg <= w_dvs_neg_next;
            r_result  <= w_result_next;
            r_ready   <= w_ready_next;
        end
    end

    assign dif.result = r_result;
    assign dif.ready  = r_ready;

`ifdef DIV_BYZERO_FLAG_EN
    logic r_zero_path;
    logic r_div_by_zero;

    // The flag tracks ready exactly, qualified by how the operation was launched.
    always_ff @(posedge clk) begin
        if (rst == c_rst_enable) begin
            r_zero_path   <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            if (r_state == DivFree) begin
                r_zero_path <= (w_state_next == DivByZero);
            end
            r_div_by_zero <= w_ready_next & r_zero_path;
        end
    end

    assign dif.div_by_zero = r_div_by_zero;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_div_unit
// Brief  : Self-checking bench for div_unit: directed table, corner sequences,
//          and random operations against an arithmetic reference model.
// Rev    : 1.0
// ============================================================================
module tb_div_unit;
    import div_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(c_reg_width)) dif();

    div_unit #(.WIDTH(c_reg_width)) dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    int n_checks = 0;
    int n_err    = 0;
    logic [c_double_reg_width-1:0] last_res;

    typedef struct {
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Plain arithmetic: C-style truncating division, remainder takes dividend sign.
    function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] as, bs;
        longint sa, sb, q, r;
        if (b == 32'h0) return 64'h0;
        as = a;
        bs = b;
        if (sd) begin
            sa = as;
            sb = bs;
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic launch(input logic sd, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dif.signed_div = sd;
        dif.opdata1    = a;
        dif.opdata2    = b;
        dif.start      = 1'b1;
        dif.annul      = 1'b0;
    endtask

    // lat = number of edges after the start edge until ready is first seen.
    task automatic wait_ready(output int lat);
        lat = -1;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!dif.ready && lat < 40);
    endtask

    task automatic release_start(input logic [63:0] held);
        @(negedge clk);
        dif.start = 1'b0;
        @(posedge clk);
        #1;
        check("drop_ready", 64'(dif.ready), 64'd0);
        check("drop_hold", dif.result, held);
`ifdef DIV_BYZERO_FLAG_EN
        check("drop_flag", 64'(dif.div_by_zero), 64'd0);
`endif
    endtask

    task automatic run_op(input string name, input logic sd, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
        int lat;
        launch(sd, a, b);
        wait_ready(lat);
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
        check({name, "_res"}, dif.result, exp);
`ifdef DIV_BYZERO_FLAG_EN
        check({name, "_flag"}, 64'(dif.div_by_zero), 64'(b == 32'h0));
`endif
        last_res = exp;
        release_start(exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [63:0] res;
        logic [63:0] exp;
        logic        sd;
        logic [31:0] a, b;

        vecs[0] = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 33};
        vecs[1] = '{1'b1, 32'hFFFFFF9C,   32'd7,        64'hFFFFFFFE_FFFFFFF2, 33};
        vecs[2] = '{1'b1, 32'd100,        32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 33};
        vecs[3] = '{1'b1, 32'd5,          32'd0,        64'h00000000_00000000, 2};
        vecs[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 33};
        vecs[5] = '{1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 33};
        vecs[6] = '{1'b0, 32'd7,          32'd100,      64'h00000007_00000000, 33};
        vecs[7] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 33};
        vecs[8] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000, 33};
        vecs[9] = '{1'b0, 32'd0,          32'd0,        64'h00000000_00000000, 2};

        rst = 1'b1;
        dif.signed_div = 1'b0;
        dif.opdata1 = '0;
        dif.opdata2 = '0;
        dif.start = 1'b0;
        dif.annul = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 64'(dif.ready), 64'd0);
        check("reset_result", dif.result, {c_zero_word, c_zero_word});
        @(negedge clk);
        rst = 1'b0;
        last_res = '0;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].sd, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        // Abort mid-operation, then restart from FREE.
        launch(1'b0, 32'hFFFFFFFF, 32'd1);
        repeat (11) @(posedge clk);
        #1;
        dif.start = 1'b0;
        dif.annul = 1'b1;
        @(posedge clk);
        #1;
        dif.annul = 1'b0;
        check("abort_ready", 64'(dif.ready), 64'd0);
        check("abort_hold", dif.result, last_res);
        run_op("restart", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33);

        // Reset lands in the middle of an operation.
        launch(1'b0, 32'd1000, 32'd3);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        dif.start = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready", 64'(dif.ready), 64'd0);
        check("midrst_result", dif.result, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        run_op("ovf_after_rst", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);

        // Start held past ready: outputs must stay put.
        launch(1'b1, 32'hFFFFFF9C, 32'd7);
        wait_ready(lat);
        res = dif.result;
        check("hold_lat", 64'(lat), 64'd33);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_ready%0d", k), 64'(dif.ready), 64'd1);
            check($sformatf("hold_res%0d", k), dif.result, 64'hFFFFFFFE_FFFFFFF2);
        end
        release_start(res);

        // Operands scrambled after the start edge must not matter.
        launch(1'b1, 32'd123456789, 32'hFFFFFF85);
        @(posedge clk);
        #1;
        dif.signed_div = 1'b0;
        dif.opdata1 = $urandom;
        dif.opdata2 = 32'd0;
        wait_ready(lat);
        check("latch_lat", 64'(lat), 64'd32);
        check("latch_res", dif.result, model(1'b1, 32'd123456789, 32'hFFFFFF85));
        last_res = dif.result;
        release_start(last_res);

        // annul together with start in FREE holds off the launch.
        launch(1'b0, 32'd100, 32'd7);
        dif.annul = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("annul_free_ready", 64'(dif.ready), 64'd0);
        @(negedge clk);
        dif.annul = 1'b0;
        wait_ready(lat);
        check("annul_free_lat", 64'(lat), 64'd33);
        check("annul_free_res", dif.result, 64'h00000002_0000000E);

        // annul in END drops ready even with start still high.
        @(negedge clk);
        dif.annul = 1'b1;
        @(posedge clk);
        #1;
        check("annul_end_ready", 64'(dif.ready), 64'd0);
        @(negedge clk);
        dif.annul = 1'b0;
        dif.start = 1'b0;
        last_res = 64'h00000002_0000000E;

        // annul in BYZERO: back to FREE, result untouched.
        launch(1'b1, 32'd5, 32'd0);
        @(posedge clk);
        @(negedge clk);
        dif.start = 1'b0;
        dif.annul = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dif.annul = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("annul_bz_ready", 64'(dif.ready), 64'd0);
        check("annul_bz_hold", dif.result, last_res);

        for (int n = 0; n < 24; n++) begin
            sd = 1'($urandom_range(0, 1));
            a  = (n % 7 == 3) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFFFFFF;
                3:       b = $urandom_range(1, 65535);
                default: b = $urandom;
            endcase
            exp = model(sd, a, b);
            run_op($sformatf("rand%0d", n), sd, a, b, exp, (b == 32'h0) ? 2 : 33);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
